car_sequencer: RTL



---
 rtl/car_sequencer_pkg.sv | 55 +++++
 rtl/car_sequencer_if.sv | 38 +++
 rtl/car_sequencer_ir_classifier.sv | 39 +++
 rtl/car_sequencer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/car_sequencer_pkg.sv
// Shared constants for the CAR microsequencer: control addresses, MSP430 opcode
// fields and source addressing modes.
package car_sequencer_pkg;

    localparam int CAR_W = 6;

    typedef enum logic [CAR_W-1:0] {
        CAR_RESET   = 6'd0,
        CAR_FETCH   = 6'd1,
        CAR_DECODE  = 6'd2,
        CAR_SRC_IDX = 6'd3,
        CAR_SRC_IND = 6'd4,
        CAR_SRC_INC = 6'd5,
        CAR_DST_IDX = 6'd6,
        CAR_DST_RD  = 6'd7,
        CAR_EXEC    = 6'd8,
        CAR_WB      = 6'd9,
        CAR_JMP     = 6'd10,
        CAR_PUSH    = 6'd11,
        CAR_CALL    = 6'd12,
        CAR_RETI_SR = 6'd13,
        CAR_RETI_PC = 6'd14,
        CAR_INT_PC  = 6'd15,
        CAR_INT_SR  = 6'd16,
        CAR_INT_VEC = 6'd17
    } carState_e;

    typedef enum logic [1:0] {
        REGISTER_MODE = 2'b00,
        INDEXED_MODE  = 2'b01,
        INDIRECT_MODE = 2'b10,
        AUTOINC_MODE  = 2'b11
    } addrMode_e;

    // Format I opcodes live in IR[15:12]; Format II opcodes in IR[9:7]
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_CMP  = 4'h9;
    localparam logic [3:0] OP_BIT  = 4'hB;
    localparam logic [2:0] OP_SXT  = 3'd3;
    localparam logic [2:0] OP_PUSH = 3'd4;
    localparam logic [2:0] OP_CALL = 3'd5;
    localparam logic [15:0] IR_RETI = 16'h1300;

    // IR[15:7] ranges covering Format II and its reserved tail
    localparam logic [8:0] FMT2_LO      = 9'h020;
    localparam logic [8:0] FMT2_RSVD_LO = 9'h027;
    localparam logic [8:0] FMT2_RSVD_HI = 9'h03F;

    function automatic logic isMemState(carState_e s);
        return s inside {CAR_RESET, CAR_FETCH, CAR_SRC_IDX, CAR_SRC_IND, CAR_SRC_INC,
                         CAR_DST_IDX, CAR_DST_RD, CAR_WB, CAR_PUSH, CAR_CALL,
                         CAR_RETI_SR, CAR_RETI_PC, CAR_INT_PC, CAR_INT_SR, CAR_INT_VEC};
    endfunction

endpackage

// File: rtl/car_sequencer_if.sv
// Sequencer-side bundle: instruction/memory/interrupt inputs and CAR/pulse outputs.
// halt/step exist only when SEQ_SINGLE_STEP_EN is defined.
interface car_sequencer_if
    import car_sequencer_pkg::*;
#(
    parameter int CAR_BITS = CAR_W
);
    logic [15:0]         IR;
    logic                mem_ready;
    logic                int_req;
    logic                gie;
    logic [CAR_BITS-1:0] CAR;
    logic                phase;
    logic                mem_req;
    logic                ir_load;
    logic                instr_done;
    logic                int_ack;
`ifdef SEQ_SINGLE_STEP_EN
    logic                halt;
    logic                step;
`endif

    modport master (
        output CAR, phase, mem_req, ir_load, instr_done, int_ack,
        input  IR, mem_ready, int_req, gie
`ifdef SEQ_SINGLE_STEP_EN
        , halt, step
`endif
    );

    modport slave (
        input  CAR, phase, mem_req, ir_load, instr_done, int_ack,
        output IR, mem_ready, int_req, gie
`ifdef SEQ_SINGLE_STEP_EN
        , halt, step
`endif
    );
endinterface

// File: rtl/car_sequencer_ir_classifier.sv
// Combinational MSP430 IR decode for the sequencer. dstMem, isPush and isCall are raw
// field decodes; the sequencer qualifies them with isFmt1 / isFmt2.
module ir_classifier
    import car_sequencer_pkg::*;
(
    input  logic [15:0] ir,
    output logic        isJump,
    output logic        isReti,
    output logic        isFmt1,
    output logic        isFmt2,
    output logic        isReserved,
    output logic        srcCg,
    output addrMode_e   srcMode,
    output logic        dstMem,
    output logic        needsWb,
    output logic        isPush,
    output logic        isCall
);
    logic [3:0] op1;
    logic [2:0] op2;
    logic [3:0] srcReg;

    assign op1        = ir[15:12];
    assign op2        = ir[9:7];
    assign isJump     = ir[15:13] == 3'b001;
    assign isReti     = ir == IR_RETI;
    assign isReserved = (ir[15:7] >= FMT2_RSVD_LO) && (ir[15:7] <= FMT2_RSVD_HI);
    assign isFmt2     = (ir[15:7] >= FMT2_LO) && (ir[15:7] < FMT2_RSVD_LO);
    assign isFmt1     = op1 >= OP_MOV;
    assign srcReg     = isFmt1 ? ir[11:8] : ir[3:0];
    assign srcMode    = addrMode_e'(ir[5:4]);
    // R3 always, and R2 in the two upper As encodings, supply constants
    assign srcCg      = (srcReg == 4'd3) || ((srcReg == 4'd2) && ir[5]);
    assign dstMem     = ir[7];
    assign isPush     = op2 == OP_PUSH;
    assign isCall     = op2 == OP_CALL;
    assign needsWb    = isFmt1 ? (dstMem && (op1 != OP_CMP) && (op1 != OP_BIT))
                               : (isFmt2 && (op2 <= OP_SXT) && (srcMode != REGISTER_MODE) && !srcCg);
endmodule

// File: rtl/car_sequencer.sv
// MSP430 microsequencer owning the CAR flop; optional halt/step control is compiled
// in with SEQ_SINGLE_STEP_EN.
//
// state      | meaning
// RESET      | reset vector read
// FETCH      | instruction fetch, pulses ir_load on completion
// DECODE     | IR classification, no memory access
// SRC_*      | source operand access (IDX: ext word then operand)
// DST_IDX/RD | destination ext word + operand, then operand read
// EXEC       | ALU step, ends the instruction unless WB follows
// WB         | result write to memory
// JMP        | PC update for jumps
// PUSH/CALL  | stack write
// RETI_SR/PC | pop SR, then PC
// INT_*      | interrupt entry: push PC, push SR, vector fetch
module car_sequencer
    import car_sequencer_pkg::*;
#(
    parameter int CAR_BITS = CAR_W
) (
    input  logic            clk,
    input  logic            rst,
    car_sequencer_if.master bus
);
    carState_e carQ, carNext, afterSrc, endNext;
    logic      phaseQ, phaseNext;
    logic      isJump, isReti, isFmt1, isFmt2, isReserved, srcCg, dstMem, needsWb, isPush, isCall;
    addrMode_e srcMode;
    logic      parked, memState, irLoad, endCycle, intAck;

    ir_classifier uClassifier (
        .ir(bus.IR), .isJump(isJump), .isReti(isReti), .isFmt1(isFmt1), .isFmt2(isFmt2),
        .isReserved(isReserved), .srcCg(srcCg), .srcMode(srcMode), .dstMem(dstMem),
        .needsWb(needsWb), .isPush(isPush), .isCall(isCall)
    );

`ifdef SEQ_SINGLE_STEP_EN
    logic stepCredit;
    // A step only counts while parked; the credit is spent by the next fetch
    assign parked = bus.halt && !stepCredit && (carQ == CAR_FETCH);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    stepCredit <= 1'b0;
        else if (parked && bus.step) stepCredit <= 1'b1;
        else if (irLoad)            stepCredit <= 1'b0;
    end
`else
    assign parked = 1'b0;
`endif

    assign endNext = (bus.int_req && bus.gie) ? CAR_INT_PC : CAR_FETCH;

    always_comb begin
        afterSrc = CAR_EXEC;
        if (isFmt1 && dstMem)      afterSrc = CAR_DST_IDX;
        else if (isFmt2 && isPush) afterSrc = CAR_PUSH;
        else if (isFmt2 && isCall) afterSrc = CAR_CALL;
    end

    always_comb begin
        carNext   = carQ;
        phaseNext = phaseQ;
        irLoad    = 1'b0;
        endCycle  = 1'b0;
        intAck    = 1'b0;
        memState  = isMemState(carQ) && !parked;
        case (carQ)
            CAR_RESET: if (bus.mem_ready) carNext = CAR_FETCH;
            CAR_FETCH: if (!parked && bus.mem_ready) begin
                carNext = CAR_DECODE;
                irLoad  = 1'b1;
            end
            CAR_DECODE: begin
                if (isJump)                                   carNext = CAR_JMP;
                else if (isReti)                              carNext = CAR_RETI_SR;
                else if (isReserved) begin
                    endCycle = 1'b1;
                    carNext  = endNext;
                end
                else if (srcCg || srcMode == REGISTER_MODE)   carNext = afterSrc;
                else if (srcMode == INDEXED_MODE)             carNext = CAR_SRC_IDX;
                else if (srcMode == INDIRECT_MODE)            carNext = CAR_SRC_IND;
                else                                          carNext = CAR_SRC_INC;
            end
            CAR_SRC_IDX, CAR_DST_IDX: if (bus.mem_ready) begin
                phaseNext = !phaseQ;
                if (phaseQ) carNext = (carQ == CAR_SRC_IDX) ? afterSrc : CAR_DST_RD;
            end
            CAR_SRC_IND, CAR_SRC_INC: if (bus.mem_ready) carNext = afterSrc;
            CAR_DST_RD:  if (bus.mem_ready) carNext = CAR_EXEC;
            CAR_EXEC: begin
                if (needsWb) carNext = CAR_WB;
                else begin
                    endCycle = 1'b1;
                    carNext  = endNext;
                end
            end
            CAR_JMP: begin
                endCycle = 1'b1;
                carNext  = endNext;
            end
            CAR_WB, CAR_PUSH, CAR_CALL, CAR_RETI_PC: if (bus.mem_ready) begin
                endCycle = 1'b1;
                carNext  = endNext;
            end
            CAR_RETI_SR: if (bus.mem_ready) carNext = CAR_RETI_PC;
            CAR_INT_PC:  if (bus.mem_ready) carNext = CAR_INT_SR;
            CAR_INT_SR:  if (bus.mem_ready) carNext = CAR_INT_VEC;
            CAR_INT_VEC: if (bus.mem_ready) begin
                intAck  = 1'b1;
                carNext = CAR_FETCH;
            end
            default: begin
                carNext   = CAR_FETCH;
                phaseNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carQ   <= CAR_RESET;
            phaseQ <= 1'b0;
        end else begin
            carQ   <= carNext;
            phaseQ <= phaseNext;
        end
    end

    assign bus.CAR        = CAR_BITS'(carQ);
    assign bus.phase      = phaseQ;
    assign bus.mem_req    = memState && !rst;
    assign bus.ir_load    = irLoad && !rst;
    assign bus.instr_done = endCycle && !rst;
    assign bus.int_ack    = intAck && !rst;
endmodule
